// File: rtl/mdu_pkg.sv
// Shared types and constants for the MiniSys-1A HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        MULU = 2'd1,
        DIV  = 2'd2,
        DIVU = 2'd3
    } mdu_op_t;

    localparam int          MDU_ITER = 32;
    localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step: shift-add for multiply, restore-subtract for divide.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // The partial remainder needs one extra bit so the trial subtraction sign is visible.
    always_comb begin
        sum_s     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted_s = {acc_hi, acc_lo[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, operand};
        if (is_div) begin
            if (!diff_s[WIDTH]) begin
                nxt_hi = diff_s[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted_s[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum_s[WIDTH:1];
            nxt_lo = {sum_s[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             op_mult,
    input  logic             op_multu,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW       = $clog2(MDU_ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(MDU_ITER - 1);

    mdu_state_t         state_r, state_nx_s;
    mdu_op_t            op_r, req_op_s;
    logic [CW-1:0]      cnt_r;
    logic               busy_r, neg_q_r, neg_r_r;
    logic [WIDTH-1:0]   hi_r, lo_r, opnd_r, acc_hi_r, acc_lo_r;
    logic [WIDTH-1:0]   core_hi_s, core_lo_s, fix_hi_s, fix_lo_s, rs_mag_s, rt_mag_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic               req_md_s, mthi_s, mtlo_s, sgn_s, is_div_s, div0_s, run_div_s;

    // Priority decode of the strobes; nothing is accepted while busy or cancelled.
    always_comb begin
        req_md_s = 1'b0;
        req_op_s = MUL;
        mthi_s   = 1'b0;
        mtlo_s   = 1'b0;
        if (ex_valid && !cancel && !busy_r) begin
            if (op_div) begin
                req_md_s = 1'b1;
                req_op_s = DIV;
            end else if (op_divu) begin
                req_md_s = 1'b1;
                req_op_s = DIVU;
            end else if (op_mult) begin
                req_md_s = 1'b1;
                req_op_s = MUL;
            end else if (op_multu) begin
                req_md_s = 1'b1;
                req_op_s = MULU;
            end else if (op_mthi) begin
                mthi_s = 1'b1;
            end else if (op_mtlo) begin
                mtlo_s = 1'b1;
            end else begin
                req_md_s = 1'b0;
            end
        end else begin
            req_md_s = 1'b0;
        end
        sgn_s    = (req_op_s == MUL) || (req_op_s == DIV);
        is_div_s = (req_op_s == DIV) || (req_op_s == DIVU);
        div0_s   = is_div_s && (rt_data == {WIDTH{1'b0}});
        rs_mag_s = (sgn_s && rs_data[WIDTH-1]) ? ({WIDTH{1'b0}} - rs_data) : rs_data;
        rt_mag_s = (sgn_s && rt_data[WIDTH-1]) ? ({WIDTH{1'b0}} - rt_data) : rt_data;
    end

    // Next-state logic; cancel overrides everything.
    always_comb begin
        state_nx_s = state_r;
        if (cancel) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_md_s) begin
                        state_nx_s = div0_s ? FIX : RUN;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                RUN: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nx_s = FIX;
                    end else begin
                        state_nx_s = RUN;
                    end
                end
                FIX:     state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    assign run_div_s = (op_r == DIV) || (op_r == DIVU);

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .is_div  (run_div_s),
        .acc_hi  (acc_hi_r),
        .acc_lo  (acc_lo_r),
        .operand (opnd_r),
        .nxt_hi  (core_hi_s),
        .nxt_lo  (core_lo_s)
    );

    // Sign fix-up applied to the magnitude result on the FIX edge.
    always_comb begin
        prod_s     = {acc_hi_r, acc_lo_r};
        prod_fix_s = neg_q_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
        if (run_div_s) begin
            fix_lo_s = neg_q_r ? ({WIDTH{1'b0}} - acc_lo_r) : acc_lo_r;
            fix_hi_s = neg_r_r ? ({WIDTH{1'b0}} - acc_hi_r) : acc_hi_r;
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Operand capture, iteration, and the single HI/LO commit point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            op_r     <= MUL;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            opnd_r   <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (state_nx_s != IDLE);
            case (state_r)
                IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (req_md_s) begin
                        op_r    <= req_op_s;
                        neg_q_r <= sgn_s && !div0_s && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_r_r <= sgn_s && is_div_s && !div0_s && rs_data[WIDTH-1];
                        if (div0_s) begin
                            acc_hi_r <= rs_data;
                            acc_lo_r <= DIV0_LO;
                        end else if (is_div_s) begin
                            opnd_r   <= rt_mag_s;
                            acc_hi_r <= {WIDTH{1'b0}};
                            acc_lo_r <= rs_mag_s;
                        end else begin
                            opnd_r   <= rs_mag_s;
                            acc_hi_r <= {WIDTH{1'b0}};
                            acc_lo_r <= rt_mag_s;
                        end
                    end
                    if (mthi_s) hi_r <= rs_data;
                    if (mtlo_s) lo_r <= rs_data;
                end
                RUN: begin
                    acc_hi_r <= core_hi_s;
                    acc_lo_r <= core_lo_s;
                    cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    if (!cancel) begin
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
                    end
                end
                default: cnt_r <= {CW{1'b0}};
            endcase
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
